// File: rtl/mem_access_ctrl.sv
// Memory-access controller between the CPU MAR/MBR side and the cache + RAM pair.
// Serves one load/store at a time: cache lookup, RAM refill on read miss, write-through stores.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_write,
    output logic [DATA_WIDTH-1:0] cache_data,
    input  logic [DATA_WIDTH-1:0] cache_found,
    input  logic                  cache_hit,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
);

    typedef enum logic [2:0] {IDLE, LOOKUP, RAM_RD, FILL, WRITE, RESP} state_t;

    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(RAM_LATENCY - 1);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  hit_q;
    logic [CW-1:0]         lat_cnt;
    logic [15:0]           hit_cnt;
    logic [15:0]           miss_cnt;
    logic                  oe_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = req_we ? WRITE : LOOKUP;
            LOOKUP:  next_state = cache_hit ? RESP : RAM_RD;
            RAM_RD:  if (lat_cnt == '0) next_state = FILL;
            FILL:    next_state = RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latching, read-data capture, RAM latency countdown and saturating statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
            hit_q    <= 1'b0;
            lat_cnt  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            oe_armed <= 1'b0;
        end else begin
            oe_armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        data_q  <= '0;
                        hit_q   <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (cache_hit) begin
                        data_q <= cache_found;
                        hit_q  <= 1'b1;
                        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                RAM_RD: begin
                    if (lat_cnt == '0) data_q  <= ram_rdata;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state so an async reset drops them at once;
    // ram_oe stays low while in reset and until the first clock afterwards.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_hit    = 1'b0;
        resp_rdata  = '0;
        cache_write = 1'b0;
        cache_data  = '0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_oe      = oe_armed;
        case (state)
            IDLE:   req_ready = 1'b1;
            RAM_RD: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
            end
            FILL: begin
                cache_write = 1'b1;
                cache_data  = data_q;
            end
            WRITE: begin
                ram_cs      = 1'b1;
                ram_we      = 1'b1;
                ram_oe      = 1'b0;
                cache_write = 1'b1;
                cache_data  = wdata_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
                resp_rdata = data_q;
            end
            default: ;
        endcase
    end

    assign cache_addr = addr_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural cache/RAM environment plus
// an ideal-cache reference model predicting data, hit flag, latency and statistics.
module tb_mem_access_ctrl;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, resp_valid, resp_hit;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] cache_addr, ram_addr;
    logic          cache_write, cache_hit, ram_cs, ram_we, ram_oe;
    logic [DW-1:0] cache_data, cache_found, ram_wdata, ram_rdata;
    logic [15:0]   hit_count, miss_count;

    mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .cache_addr(cache_addr), .cache_write(cache_write), .cache_data(cache_data),
        .cache_found(cache_found), .cache_hit(cache_hit),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
        if (a == 18'h105) return 16'h1234;
        return (a[15:0] * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Environment: ideal cache and RAM responding to the DUT's pins
    bit [DW-1:0] env_ram   [0:(1<<AW)-1];
    bit          env_ram_w [0:(1<<AW)-1];
    bit [DW-1:0] env_cache [0:(1<<AW)-1];
    bit          env_valid [0:(1<<AW)-1];

    always_comb begin
        cache_hit   = env_valid[cache_addr];
        cache_found = env_cache[cache_addr];
        ram_rdata   = '0;
        if (ram_cs && ram_oe && !ram_we)
            ram_rdata = env_ram_w[ram_addr] ? env_ram[ram_addr] : initVal(ram_addr);
    end

    int mon_cs = 0, mon_we = 0, mon_cw = 0, mon_accept = 0, mon_conflict = 0;
    logic [AW-1:0] mon_cw_addr = '0;

    always @(posedge clk) begin
        if (cache_write) begin
            env_cache[cache_addr] <= cache_data;
            env_valid[cache_addr] <= 1'b1;
            mon_cw      <= mon_cw + 1;
            mon_cw_addr <= cache_addr;
        end
        if (ram_cs && ram_we && !ram_oe) begin
            env_ram[ram_addr]   <= ram_wdata;
            env_ram_w[ram_addr] <= 1'b1;
        end
        if (ram_cs) mon_cs <= mon_cs + 1;
        if (ram_cs && ram_we) mon_we <= mon_we + 1;
        if (ram_we && ram_oe) mon_conflict <= mon_conflict + 1;
        if (req_valid && req_ready && !rst) mon_accept <= mon_accept + 1;
    end

    // Reference model: every address ever stored or loaded stays cached
    bit [DW-1:0] ref_mem    [0:(1<<AW)-1];
    bit          ref_mem_w  [0:(1<<AW)-1];
    bit          ref_cached [0:(1<<AW)-1];
    int          ref_hits = 0, ref_misses = 0;

    int checks = 0, passes = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic refExpect(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                             output logic exp_hit, output logic [DW-1:0] exp_data, output int exp_lat);
        if (we) begin
            ref_mem[a] = wd; ref_mem_w[a] = 1'b1; ref_cached[a] = 1'b1;
            exp_hit = 1'b0; exp_data = '0; exp_lat = 2;
        end else begin
            exp_data = ref_mem_w[a] ? ref_mem[a] : initVal(a);
            if (ref_cached[a]) begin
                exp_hit = 1'b1; exp_lat = 2;
                ref_hits = (ref_hits < 65535) ? ref_hits + 1 : 65535;
            end else begin
                exp_hit = 1'b0; exp_lat = 3 + LAT;
                ref_cached[a] = 1'b1;
                ref_misses = (ref_misses < 65535) ? ref_misses + 1 : 65535;
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit busy);
        logic exp_hit; logic [DW-1:0] exp_data; int exp_lat, k;
        int s_cs, s_we, s_cw, s_acc, s_conf;
        refExpect(we, a, wd, exp_hit, exp_data, exp_lat);
        @(negedge clk);
        s_cs = mon_cs; s_we = mon_we; s_cw = mon_cw; s_acc = mon_accept; s_conf = mon_conflict;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        checkOutput("ready", req_ready, 1);
        @(negedge clk);
        k = 1;
        if (!busy) req_valid = 1'b0;
        else begin req_addr = AW'($urandom); req_we = 1'b0; end
        while (!resp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        checkOutput("latency", k, exp_lat);
        checkOutput("rdata", resp_rdata, exp_data);
        checkOutput("hit", resp_hit, exp_hit);
        checkOutput("hit_count", hit_count, ref_hits);
        checkOutput("miss_count", miss_count, ref_misses);
        checkOutput("accepts", mon_accept - s_acc, 1);
        checkOutput("ram_cs_cycles", mon_cs - s_cs, we ? 1 : (exp_hit ? 0 : LAT));
        checkOutput("ram_we_cycles", mon_we - s_we, we ? 1 : 0);
        checkOutput("cache_writes", mon_cw - s_cw, (we || !exp_hit) ? 1 : 0);
        checkOutput("bus_conflict", mon_conflict - s_conf, 0);
        if (we || !exp_hit) checkOutput("cache_write_addr", mon_cw_addr, a);
    endtask

    initial begin
        int seen;
        #2;
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_ram_cs", ram_cs, 0);
        checkOutput("rst_ram_oe", ram_oe, 0);
        checkOutput("rst_cache_write", cache_write, 0);
        checkOutput("rst_counts", {hit_count, miss_count}, 0);
        checkOutput("rst_addr", cache_addr, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a RAM read
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h120;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_ram_cs_before", ram_cs, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_ram_cs_after", ram_cs, 0);
        checkOutput("mid_ready_after", req_ready, 1);
        checkOutput("mid_counts", {hit_count, miss_count}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        checkOutput("aborted_resp", seen, 0);

        applyStimulus(1'b0, 18'h105, 16'h0, 1'b0);
        applyStimulus(1'b0, 18'h105, 16'h0, 1'b0);
        applyStimulus(1'b1, 18'h106, 16'h00AB, 1'b0);
        applyStimulus(1'b0, 18'h106, 16'h0, 1'b0);
        applyStimulus(1'b0, 18'h110, 16'h0, 1'b1);

        for (int i = 0; i < 40; i++)
            applyStimulus(1'($urandom_range(0, 1)), 18'h100 + AW'($urandom_range(0, 31)),
                          DW'($urandom), 1'($urandom_range(0, 1)));

        // Saturation of the hit counter
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFE;
        #1 release dut.hit_cnt;
        ref_hits = 16'hFFFE;
        checkOutput("forced_hit_count", hit_count, 16'hFFFE);
        repeat (3) applyStimulus(1'b0, 18'h105, 16'h0, 1'b0);
        checkOutput("saturated", hit_count, 16'hFFFF);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
